// File: rtl/tdm_mux_pkg.sv
// tdm_mux_pkg: constants and FSM state type shared by the TDM multiplexer and demultiplexer.
package tdm_mux_pkg;
  localparam int TDM_SLOTS = 4;
  localparam int TDM_SLOT_W = 2;
  typedef enum logic {IDLE, RUN} tdm_state_t;
endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: wrapping slot counter with advance enable and synchronous load-to-1.
module tdm_slot_counter
  import tdm_mux_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  adv,
  input  logic                  load1,
  output logic [TDM_SLOT_W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load1) cnt <= TDM_SLOT_W'(1);
    else if (adv) cnt <= cnt + TDM_SLOT_W'(1);
endmodule

// File: rtl/tdm_demux_1_to_4.sv
// tdm_demux_1_to_4: serial 4-slot TDM frame demultiplexer with sync lock.
// Define TDM_DEMUX_SYNC_CHECK_EN to enable the sticky misaligned-sync flag sync_err.
module tdm_demux_1_to_4
  import tdm_mux_pkg::*;
#(
  parameter logic [TDM_SLOTS-1:0] OUT_RST = 4'b0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din,
  input  logic                  din_valid,
  input  logic                  sync,
  input  logic                  err_clr,
  output logic [TDM_SLOTS-1:0]  q,
  output logic                  q_valid,
  output logic [TDM_SLOT_W-1:0] slot,
  output logic                  locked,
  output logic                  sync_err
);
  tdm_state_t state, state_nx;
  logic [TDM_SLOTS-2:0] asm_q, asm_nx;
  logic [TDM_SLOTS-1:0] q_nx;
  logic qv_nx, adv, load1, mis;
  tdm_slot_counter u_cnt (
    .clk(clk),
    .rst(rst),
    .adv(adv),
    .load1(load1),
    .cnt(slot)
  );
  always_comb begin
    state_nx = state;
    asm_nx = asm_q;
    q_nx = q;
    qv_nx = 1'b0;
    adv = 1'b0;
    load1 = 1'b0;
    mis = 1'b0;
    if (din_valid) begin
      if (state == IDLE) begin
        if (sync) begin
          state_nx = RUN;
          asm_nx = {{(TDM_SLOTS-2){1'b0}}, din};
          load1 = 1'b1;
        end
      end else if (sync && slot != '0) begin
        // realign: this beat becomes slot 0 of a fresh frame
        mis = 1'b1;
        asm_nx = {{(TDM_SLOTS-2){1'b0}}, din};
        load1 = 1'b1;
      end else if (slot == TDM_SLOT_W'(TDM_SLOTS-1)) begin
        q_nx = {din, asm_q};
        qv_nx = 1'b1;
        adv = 1'b1;
      end else begin
        asm_nx[slot] = din;
        adv = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      asm_q <= '0;
      q <= OUT_RST;
      q_valid <= 1'b0;
    end else begin
      state <= state_nx;
      asm_q <= asm_nx;
      q <= q_nx;
      q_valid <= qv_nx;
    end
  assign locked = (state == RUN);
`ifdef TDM_DEMUX_SYNC_CHECK_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) sync_err <= 1'b0;
    else if (mis) sync_err <= 1'b1;
    else if (err_clr) sync_err <= 1'b0;
`else
  logic unused_err;
  assign unused_err = err_clr ^ mis;
  assign sync_err = 1'b0;
`endif
endmodule

// File: tb/tb_tdm_demux_1_to_4.sv
// tb_tdm_demux_1_to_4: directed and randomized checks against a frame-queue reference model.
module tb_tdm_demux_1_to_4;
  logic clk = 1'b0, rst = 1'b1, din = 1'b0, din_valid = 1'b0, sync = 1'b0, err_clr = 1'b0;
  logic [3:0] q;
  logic q_valid, locked, sync_err;
  logic [1:0] slot;
  int checks = 0, failures = 0;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  bit m_locked = 1'b0, m_qv = 1'b0, m_err = 1'b0;
  bit [3:0] m_q = 4'b0000;
  bit frame[$];

  tdm_demux_1_to_4 dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
    .err_clr(err_clr), .q(q), .q_valid(q_valid), .slot(slot),
    .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".q"}, q, m_q);
    chk({tag, ".q_valid"}, {3'b0, q_valid}, {3'b0, m_qv});
    chk({tag, ".slot"}, {2'b0, slot}, 4'(frame.size()));
    chk({tag, ".locked"}, {3'b0, locked}, {3'b0, m_locked});
    chk({tag, ".sync_err"}, {3'b0, sync_err}, {3'b0, m_err});
  endtask

  task automatic model_reset();
    m_locked = 1'b0; m_qv = 1'b0; m_err = 1'b0; m_q = 4'b0000;
    frame.delete();
  endtask

  task automatic model(input bit v, input bit s, input bit d, input bit c);
    m_qv = 1'b0;
    if (c) m_err = 1'b0;
    if (v && s) begin
      if (m_locked && frame.size() != 0) m_err = ERR_EN;
      frame.delete();
      frame.push_back(d);
      m_locked = 1'b1;
    end else if (v && m_locked) begin
      frame.push_back(d);
      if (frame.size() == 4) begin
        m_q = {frame[3], frame[2], frame[1], frame[0]};
        m_qv = 1'b1;
        frame.delete();
      end
    end
  endtask

  task automatic step(input string tag, input bit v, input bit s, input bit d, input bit c);
    @(negedge clk);
    din_valid = v; sync = s; din = d; err_clr = c;
    @(posedge clk);
    model(v, s, d, c);
    #1;
    chk_all(tag);
  endtask

  initial begin
    #12;
    chk_all("reset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step("nosync", 1'b1, 1'b0, 1'($urandom), 1'b0);
    chk("nosync_q", q, 4'b0000);
    step("f1", 1'b1, 1'b1, 1'b1, 1'b0);
    step("f1", 1'b1, 1'b0, 1'b0, 1'b0);
    step("f1", 1'b1, 1'b0, 1'b1, 1'b0);
    step("f1", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("f1_q", q, 4'b1101);
    chk("f1_pulse", {3'b0, q_valid}, 4'd1);
    step("f1_end", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("f1_pulse_gone", {3'b0, q_valid}, 4'd0);
    step("b2b", 1'b1, 1'b1, 1'b1, 1'b0);
    step("b2b", 1'b1, 1'b0, 1'b0, 1'b0);
    step("b2b", 1'b1, 1'b0, 1'b0, 1'b0);
    step("b2b", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("b2b_q0", q, 4'b0001);
    step("b2b", 1'b1, 1'b0, 1'b0, 1'b0);
    step("b2b", 1'b1, 1'b0, 1'b0, 1'b0);
    step("b2b", 1'b1, 1'b0, 1'b0, 1'b0);
    step("b2b", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("b2b_q1", q, 4'b1000);
    step("mis", 1'b1, 1'b0, 1'b1, 1'b0);
    step("mis", 1'b1, 1'b0, 1'b1, 1'b0);
    step("mis", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("mis_slot", {2'b0, slot}, 4'd1);
    step("mis", 1'b1, 1'b0, 1'b1, 1'b0);
    step("mis", 1'b1, 1'b0, 1'b0, 1'b0);
    step("mis", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("mis_q", q, 4'b1010);
    step("gap", 1'b1, 1'b1, 1'b0, 1'b0);
    step("gap", 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("gap_hold", 1'b0, 1'($urandom), 1'($urandom), 1'b0);
    chk("gap_slot", {2'b0, slot}, 4'd2);
    step("gap", 1'b1, 1'b0, 1'b1, 1'b0);
    step("gap", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("gap_q", q, 4'b0110);
    step("arst", 1'b1, 1'b1, 1'b1, 1'b0);
    step("arst", 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    din_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk_all("arst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 400; i++)
      step("rand", $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2, 1'($urandom),
           $urandom_range(0, 19) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
